// File: rtl/fwd_track_if.sv
// Issue, lookup and status signals between the DEC stage and the forwarding tracker.
// The DEC side takes the master modport; the tracker takes the slave modport.
interface fwd_track_if #(
  parameter int LANES  = 2,
  parameter int STAGES = 3,
  parameter int RPORTS = 4,
  parameter int LATW   = 2
);
  localparam int SW = $clog2(STAGES);
  localparam int LW = $clog2(LANES);

  logic                   adv;
  logic                   flush;
  logic [LANES-1:0]       iss_valid;
  logic [LANES-1:0]       iss_wr;
  logic [LANES*5-1:0]     iss_rd;
  logic [LANES*LATW-1:0]  iss_lat;
  logic [RPORTS*5-1:0]    rs_addr;
  logic [RPORTS-1:0]      fwd_hit;
  logic [RPORTS-1:0]      fwd_ready;
  logic [RPORTS*SW-1:0]   fwd_stage;
  logic [RPORTS*LW-1:0]   fwd_lane;
  logic                   busy;

  modport master (
    output adv, flush, iss_valid, iss_wr, iss_rd, iss_lat, rs_addr,
    input  fwd_hit, fwd_ready, fwd_stage, fwd_lane, busy
  );

  modport slave (
    input  adv, flush, iss_valid, iss_wr, iss_rd, iss_lat, rs_addr,
    output fwd_hit, fwd_ready, fwd_stage, fwd_lane, busy
  );
endinterface

// File: rtl/fwd_track.sv
// Forwarding tracker: shadows EX1..EXn register writes and reports, per read port,
// the youngest in-flight producer, its stage/lane and whether it can forward next cycle.
module fwd_track #(
  parameter int LANES  = 2,
  parameter int STAGES = 3,
  parameter int RPORTS = 4,
  parameter int LATW   = 2
) (
  input  logic        clk,
  input  logic        rst,
  fwd_track_if.slave  bus
);
  localparam int SW = $clog2(STAGES);
  localparam int LW = $clog2(LANES);

  typedef struct packed {
    logic [4:0]      rd;
    logic [LATW-1:0] lat;
  } ent_t;

  logic [STAGES-1:0][LANES-1:0] vld;
  ent_t [STAGES-1:0][LANES-1:0] ent;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      vld <= '0;
    end else if (bus.adv) begin
      for (int s = STAGES-1; s > 0; s--) vld[s] <= vld[s-1];
      for (int l = 0; l < LANES; l++)
        vld[0][l] <= bus.iss_valid[l] & bus.iss_wr[l] & (bus.iss_rd[l*5 +: 5] != 5'd0);
    end
  end

  // NOTE: payload is deliberately left out of reset; it is only ever read when the
  // matching vld bit is set, so clearing vld alone is enough.
  always_ff @(posedge clk) begin
    if (bus.adv) begin
      for (int s = STAGES-1; s > 0; s--) ent[s] <= ent[s-1];
      for (int l = 0; l < LANES; l++) begin
        ent[0][l].rd  <= bus.iss_rd[l*5 +: 5];
        // A zero latency means "ready at end of EX1", same as one.
        ent[0][l].lat <= (bus.iss_lat[l*LATW +: LATW] == '0) ? LATW'(1)
                                                              : bus.iss_lat[l*LATW +: LATW];
      end
    end
  end

  logic [RPORTS-1:0]    hit_c;
  logic [RPORTS-1:0]    ready_c;
  logic [RPORTS*SW-1:0] stage_c;
  logic [RPORTS*LW-1:0] lane_c;

  // Scan from lowest to highest priority so the last match written wins:
  // oldest stage first, lane 0 first within a stage.
  always_comb begin
    hit_c   = '0;
    ready_c = '1;
    stage_c = '0;
    lane_c  = '0;
    for (int p = 0; p < RPORTS; p++) begin
      if (bus.rs_addr[p*5 +: 5] != 5'd0) begin
        for (int s = STAGES-1; s >= 0; s--) begin
          for (int l = 0; l < LANES; l++) begin
            if (vld[s][l] && ent[s][l].rd == bus.rs_addr[p*5 +: 5]) begin
              hit_c[p]            = 1'b1;
              ready_c[p]          = (int'(ent[s][l].lat) <= s + 1);
              stage_c[p*SW +: SW] = SW'(s);
              lane_c[p*LW +: LW]  = LW'(l);
            end
          end
        end
      end
    end
  end

  assign bus.fwd_hit   = hit_c;
  assign bus.fwd_ready = ready_c;
  assign bus.fwd_stage = stage_c;
  assign bus.fwd_lane  = lane_c;
  assign bus.busy      = |vld;

endmodule

// File: tb/tb_fwd_track.sv
// Scenario bench for fwd_track: each task queues expected lookups on a scoreboard,
// which are applied to the read ports in parallel and compared against the DUT.
module tb_fwd_track;
  localparam int LANES  = 2;
  localparam int STAGES = 3;
  localparam int RPORTS = 4;
  localparam int LATW   = 2;
  localparam int SW     = $clog2(STAGES);
  localparam int LW     = $clog2(LANES);

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  fwd_track_if #(.LANES(LANES), .STAGES(STAGES), .RPORTS(RPORTS), .LATW(LATW)) bus ();

  fwd_track #(.LANES(LANES), .STAGES(STAGES), .RPORTS(RPORTS), .LATW(LATW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string           name;
    logic [4:0]      rs;
    logic            hit;
    logic            ready;
    logic [SW-1:0]   stage;
    logic [LW-1:0]   lane;
  } exp_t;

  exp_t sb[$];

  task automatic expect_lookup(input string name, input logic [4:0] rs, input logic hit,
                               input logic ready, input int stage, input int lane);
    exp_t e;
    e.name  = name;
    e.rs    = rs;
    e.hit   = hit;
    e.ready = ready;
    e.stage = SW'(stage);
    e.lane  = LW'(lane);
    sb.push_back(e);
  endtask

  // Pops up to RPORTS expectations at a time, one per read port, and compares them.
  task automatic sb_drain();
    exp_t cur[$];
    logic [SW+LW+1:0] got, want;
    while (sb.size() > 0) begin
      cur = {};
      bus.rs_addr = '0;
      for (int p = 0; p < RPORTS && sb.size() > 0; p++) begin
        cur.push_back(sb.pop_front());
        bus.rs_addr[p*5 +: 5] = cur[p].rs;
      end
      #1;
      foreach (cur[p]) begin
        got  = {bus.fwd_hit[p], bus.fwd_ready[p], bus.fwd_stage[p*SW +: SW], bus.fwd_lane[p*LW +: LW]};
        want = {cur[p].hit, cur[p].ready, cur[p].stage, cur[p].lane};
        checks++;
        if (got !== want)
          $display("FAIL %s port%0d rs=%0d: got hit/ready/stage/lane=%b/%b/%0d/%0d want %b/%b/%0d/%0d",
                   cur[p].name, p, cur[p].rs, got[SW+LW+1], got[SW+LW], got[SW+LW-1:LW], got[LW-1:0],
                   want[SW+LW+1], want[SW+LW], want[SW+LW-1:LW], want[LW-1:0]);
        else
          passes++;
      end
    end
  endtask

  task automatic check_busy(input string name, input logic want);
    checks++;
    if (bus.busy !== want)
      $display("FAIL %s busy: got %b want %b", name, bus.busy, want);
    else
      passes++;
  endtask

  task automatic set_lane(input int l, input logic wr, input logic [4:0] rd, input logic [LATW-1:0] lat);
    bus.iss_valid[l]           = 1'b1;
    bus.iss_wr[l]              = wr;
    bus.iss_rd[l*5 +: 5]       = rd;
    bus.iss_lat[l*LATW +: LATW] = lat;
  endtask

  // One clock with the given adv/flush; issue inputs are cleared afterwards.
  task automatic step(input logic a, input logic f);
    bus.adv   = a;
    bus.flush = f;
    @(posedge clk);
    #1;
    bus.adv       = 1'b0;
    bus.flush     = 1'b0;
    bus.iss_valid = '0;
    bus.iss_wr    = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_lane(0, 1'b1, 5'd3, 2'd1);
    set_lane(1, 1'b1, 5'd4, 2'd1);
    bus.adv = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.adv       = 1'b0;
    bus.iss_valid = '0;
    bus.iss_wr    = '0;
    check_busy("reset", 1'b0);
    expect_lookup("reset_rs3", 5'd3, 1'b0, 1'b1, 0, 0);
    expect_lookup("reset_rs4", 5'd4, 1'b0, 1'b1, 0, 0);
    expect_lookup("reset_rs0", 5'd0, 1'b0, 1'b1, 0, 0);
    expect_lookup("reset_rs31", 5'd31, 1'b0, 1'b1, 0, 0);
    sb_drain();
  endtask

  task automatic test_alu_walk();
    set_lane(0, 1'b1, 5'd5, 2'd1);
    step(1'b1, 1'b0);
    check_busy("alu_issued", 1'b1);
    expect_lookup("alu_s0", 5'd5, 1'b1, 1'b1, 0, 0);
    sb_drain();
    step(1'b1, 1'b0);
    expect_lookup("alu_s1", 5'd5, 1'b1, 1'b1, 1, 0);
    sb_drain();
    step(1'b1, 1'b0);
    expect_lookup("alu_s2", 5'd5, 1'b1, 1'b1, 2, 0);
    sb_drain();
    step(1'b1, 1'b0);
    expect_lookup("alu_gone", 5'd5, 1'b0, 1'b1, 0, 0);
    sb_drain();
    check_busy("alu_drained", 1'b0);
  endtask

  task automatic test_load();
    set_lane(0, 1'b1, 5'd7, 2'd3);
    step(1'b1, 1'b0);
    expect_lookup("load_s0", 5'd7, 1'b1, 1'b0, 0, 0);
    sb_drain();
    step(1'b1, 1'b0);
    expect_lookup("load_s1", 5'd7, 1'b1, 1'b0, 1, 0);
    sb_drain();
    step(1'b1, 1'b0);
    expect_lookup("load_s2", 5'd7, 1'b1, 1'b1, 2, 0);
    sb_drain();
    step(1'b1, 1'b0);
  endtask

  task automatic test_shadow();
    set_lane(0, 1'b1, 5'd9, 2'd1);
    set_lane(1, 1'b1, 5'd9, 2'd1);
    step(1'b1, 1'b0);
    expect_lookup("shadow_lane1", 5'd9, 1'b1, 1'b1, 0, 1);
    sb_drain();
    set_lane(0, 1'b1, 5'd9, 2'd2);
    step(1'b1, 1'b0);
    expect_lookup("shadow_younger", 5'd9, 1'b1, 1'b0, 0, 0);
    sb_drain();
    repeat (3) step(1'b1, 1'b0);
  endtask

  task automatic test_lat_edge();
    set_lane(0, 1'b1, 5'd20, 2'd0);
    set_lane(1, 1'b0, 5'd21, 2'd1);
    step(1'b1, 1'b0);
    expect_lookup("lat0_as_1", 5'd20, 1'b1, 1'b1, 0, 0);
    expect_lookup("no_wr", 5'd21, 1'b0, 1'b1, 0, 0);
    sb_drain();
    repeat (3) step(1'b1, 1'b0);
  endtask

  task automatic test_zero_hold();
    set_lane(0, 1'b1, 5'd0, 2'd1);
    step(1'b1, 1'b0);
    check_busy("rd0_not_tracked", 1'b0);
    expect_lookup("rs0_miss", 5'd0, 1'b0, 1'b1, 0, 0);
    sb_drain();
    set_lane(1, 1'b1, 5'd12, 2'd3);
    step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      set_lane(0, 1'b1, 5'd13, 2'd1);
      step(1'b0, 1'b0);
      expect_lookup("hold_s0", 5'd12, 1'b1, 1'b0, 0, 1);
      expect_lookup("hold_ignored", 5'd13, 1'b0, 1'b1, 0, 0);
      sb_drain();
    end
    step(1'b1, 1'b0);
    expect_lookup("hold_then_s1", 5'd12, 1'b1, 1'b0, 1, 1);
    sb_drain();
    step(1'b1, 1'b0);
    expect_lookup("hold_then_s2", 5'd12, 1'b1, 1'b1, 2, 1);
    sb_drain();
    step(1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    set_lane(0, 1'b1, 5'd1, 2'd1);
    set_lane(1, 1'b1, 5'd2, 2'd2);
    step(1'b1, 1'b0);
    set_lane(0, 1'b1, 5'd3, 2'd3);
    set_lane(1, 1'b1, 5'd1, 2'd2);
    step(1'b1, 1'b0);
    set_lane(0, 1'b1, 5'd2, 2'd1);
    step(1'b1, 1'b0);
    expect_lookup("b2b_rs1", 5'd1, 1'b1, 1'b1, 1, 1);
    expect_lookup("b2b_rs2", 5'd2, 1'b1, 1'b1, 0, 0);
    expect_lookup("b2b_rs3", 5'd3, 1'b1, 1'b0, 1, 0);
    expect_lookup("b2b_rs4", 5'd4, 1'b0, 1'b1, 0, 0);
    sb_drain();
    repeat (3) step(1'b1, 1'b0);
  endtask

  task automatic test_flush_reset();
    set_lane(0, 1'b1, 5'd4, 2'd1);
    step(1'b1, 1'b0);
    check_busy("pre_flush", 1'b1);
    set_lane(0, 1'b1, 5'd6, 2'd1);
    step(1'b1, 1'b1);
    check_busy("flush", 1'b0);
    expect_lookup("flush_old", 5'd4, 1'b0, 1'b1, 0, 0);
    expect_lookup("flush_dropped", 5'd6, 1'b0, 1'b1, 0, 0);
    sb_drain();
    set_lane(0, 1'b1, 5'd4, 2'd1);
    step(1'b1, 1'b0);
    set_lane(1, 1'b1, 5'd6, 2'd1);
    rst = 1'b1;
    step(1'b1, 1'b0);
    rst = 1'b0;
    check_busy("mid_reset", 1'b0);
    expect_lookup("mid_reset_old", 5'd4, 1'b0, 1'b1, 0, 0);
    expect_lookup("mid_reset_new", 5'd6, 1'b0, 1'b1, 0, 0);
    sb_drain();
  endtask

  initial begin
    rst           = 1'b1;
    bus.adv       = 1'b0;
    bus.flush     = 1'b0;
    bus.iss_valid = '0;
    bus.iss_wr    = '0;
    bus.iss_rd    = '0;
    bus.iss_lat   = '0;
    bus.rs_addr   = '0;
    @(negedge clk);
    test_reset();
    test_alu_walk();
    test_load();
    test_shadow();
    test_lat_edge();
    test_zero_hold();
    test_back_to_back();
    test_flush_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
